coreir_pack_slices: RTL and testbench
=====================================

COREIR_PACK_SLICES -- requirements
Module: coreir_pack_slices

Interface
REQ-001 Parameter width, default 32'd16, is the input word width.
REQ-002 Parameter hi, default 32'd16, is the exclusive upper bound of the extracted field; lo < hi <= width.
REQ-003 Parameter lo, default 32'd12, is the inclusive lower bound of the extracted field.
REQ-004 Parameter count, default 32'd4, is the number of fields per output word, with count >= 2.
REQ-005 Derived constant F = hi-lo is the field width; output width is F*count.
REQ-006 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-007 Port arst, input, 1 bit, is an asynchronous, active-low reset.
REQ-008 Port in, input, width bits, is the input word.
REQ-009 Port in_valid, input, 1 bit, means in carries a word.
REQ-010 Port in_ready, output, 1 bit, means the block accepts in this cycle.
REQ-011 Port flush, input, 1 bit, requests emission of a partially filled word.
REQ-012 Port out, output, F*count bits, is the packed word.
REQ-013 Port out_cnt, output, 32 bits, is the number of valid fields in out (1..count).
REQ-014 Port out_valid, output, 1 bit, means out and out_cnt are valid.
REQ-015 Port out_ready, input, 1 bit, means the consumer takes out this cycle.

Function
REQ-016 Accept = in_valid & in_ready; field = in[hi-1:lo].
REQ-017 Internal state: accumulator acc (F*count bits), index idx (0..count-1), sticky flush_pend, and output register (out, out_cnt, out_valid).
REQ-018 On accept, the field is written to acc[(idx+1)*F-1 : idx*F], so earlier fields occupy lower bits, matching the {in1,in0} order of coreir_concat.
REQ-019 slot_free = !out_valid | out_ready.
REQ-020 in_ready = slot_free | (idx != count-1); it is combinational and does not depend on in_valid.
REQ-021 Full word: accept with idx == count-1 loads out with acc plus the new field, sets out_cnt = count and out_valid = 1, and clears acc and idx to 0 in the same edge; latency is one cycle from the final accept to out_valid.
REQ-022 A non-final accept increments idx without changing the output register.
REQ-023 flush high sets flush_pend, which stays set until serviced.
REQ-024 flush_pend (or flush) is serviced on an edge where slot_free is true and either idx > 0 or an accept occurs.
REQ-025 When serviced, out is loaded with acc (including any same-cycle field), unfilled upper fields are zero, out_cnt = idx (+1 if a field was accepted that cycle), out_valid = 1, and acc, idx and flush_pend are cleared.
REQ-026 flush with idx == 0 and no accept clears flush_pend and emits nothing.
REQ-027 If a same-cycle accept completes a full word, full-word rules apply and flush_pend clears.
REQ-028 When out_valid & out_ready and no new load occurs, out_valid clears; out and out_cnt hold their last values.
REQ-029 A new load takes priority over the drain, so out_valid stays 1 for back-to-back words with no bubble.
REQ-030 While out_valid & !out_ready, out and out_cnt remain stable.

Reset
REQ-031 arst low immediately forces out_valid = 0, out = 0, out_cnt = 0, acc = 0, idx = 0 and flush_pend = 0, independent of clk.
REQ-032 A reset asserted mid-word discards all partial fields.
REQ-033 After arst deasserts, in_ready = 1 and the first accepted field lands at bits [F-1:0].

Verification
REQ-034 Defaults; accept 16'h1000, 16'h2000, 16'h3000, 16'h4000 on consecutive cycles with out_ready = 1 -> one cycle after the 4th accept, out = 16'h4321, out_cnt = 4 and out_valid is high for one cycle.
REQ-035 Two fields 16'hA000, 16'hB000, then flush pulsed for 1 cycle -> out = 16'h00BA, out_cnt = 2; a further flush with idx = 0 produces no output.
REQ-036 Hold out_ready = 0 with one full word pending and idx = 3 -> in_ready = 0 and further in_valid is not accepted; release out_ready -> the 4th field is accepted that cycle and the next word follows with no bubble.
REQ-037 flush asserted in the same cycle as the 4th accept -> a single output with out_cnt = 4 and flush_pend clear afterwards.
REQ-038 Assert arst low asynchronously, mid-cycle, after 2 accepts -> out_valid drops immediately; after release, 4 new accepts yield a word containing only the new fields.
REQ-039 Parameters width = 32, hi = 9, lo = 1, count = 3; accept 32'h1FE, 32'h002, 32'h100 -> out = 24'h80_01_FF.

Source files
------------

// File: rtl/coreir_pack_slices.sv
// coreir_pack_slices
//   Extracts the bit field in[hi-1:lo] from each accepted input word and packs
//   `count` consecutive fields into one output word. The earliest field sits in
//   the lowest bits, which matches the {in1,in0} ordering of coreir_concat.
//   A flush request emits a partially filled word with its upper fields zeroed.
//   The output is a single registered slot with a valid/ready handshake.
//
// Parameters
//   width  - input word width
//   hi     - exclusive upper bound of the extracted field (hi <= width)
//   lo     - inclusive lower bound of the extracted field (lo < hi)
//   count  - fields per output word (count >= 2)
//
// Ports
//   clk        - clock; all state changes on the rising edge
//   arst       - asynchronous reset, active low
//   in         - input word
//   in_valid   - in carries a word
//   in_ready   - block accepts in this cycle (independent of in_valid)
//   flush      - request emission of a partially filled word (sticky)
//   out        - packed word, (hi-lo)*count bits
//   out_cnt    - number of valid fields in out (1..count)
//   out_valid  - out and out_cnt are valid
//   out_ready  - consumer takes out this cycle
module coreir_pack_slices #(
  parameter int unsigned width = 32'd16,
  parameter int unsigned hi    = 32'd16,
  parameter int unsigned lo    = 32'd12,
  parameter int unsigned count = 32'd4
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic [width-1:0]            in,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [(hi-lo)*count-1:0]    out,
  output logic [31:0]                 out_cnt,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int unsigned F  = hi - lo;
  localparam int unsigned OW = F * count;
  localparam int unsigned IW = (count > 1) ? $clog2(count) : 1;

  logic [OW-1:0] acc_p0;
  logic [IW-1:0] idx_p0;
  logic          flush_pend_p0;

  logic [F-1:0]  field;
  logic [OW-1:0] acc_next;
  logic          slot_free;
  logic          last_slot;
  logic          accept;
  logic          pend;
  logic          full_word;
  logic          service;
  logic          idx_zero;

  assign field     = in[hi-1:lo];
  assign slot_free = !out_valid || out_ready;
  assign last_slot = (idx_p0 == IW'(count - 1));
  // Only the field that completes a word needs the output slot; earlier fields
  // go into the accumulator, so the block keeps accepting while the slot is busy.
  assign in_ready  = slot_free || !last_slot;
  assign accept    = in_valid && in_ready;
  assign idx_zero  = (idx_p0 == '0);
  assign pend      = flush_pend_p0 || flush;
  assign full_word = accept && last_slot;
  // A flush is serviceable only if there is at least one field to emit,
  // counting a field accepted in this same cycle.
  assign service   = pend && slot_free && (!idx_zero || accept);

  always_comb begin
    acc_next = acc_p0;
    for (int k = 0; k < int'(count); k++) begin
      if (accept && (idx_p0 == IW'(k))) begin
        acc_next[k*F +: F] = field;
      end
    end
  end

  // Stage p0 -> output register
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      acc_p0        <= '0;
      idx_p0        <= '0;
      flush_pend_p0 <= 1'b0;
      out           <= '0;
      out_cnt       <= '0;
      out_valid     <= 1'b0;
    end else if (full_word) begin
      out           <= acc_next;
      out_cnt       <= count;
      out_valid     <= 1'b1;
      acc_p0        <= '0;
      idx_p0        <= '0;
      flush_pend_p0 <= 1'b0;
    end else if (service) begin
      out           <= acc_next;
      out_cnt       <= 32'(idx_p0) + (accept ? 32'd1 : 32'd0);
      out_valid     <= 1'b1;
      acc_p0        <= '0;
      idx_p0        <= '0;
      flush_pend_p0 <= 1'b0;
    end else begin
      if (accept) begin
        acc_p0 <= acc_next;
        idx_p0 <= idx_p0 + IW'(1);
      end
      // A flush with nothing buffered and nothing arriving has no work to do.
      flush_pend_p0 <= pend && !(idx_zero && !accept);
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_coreir_pack_slices.sv
module tb_coreir_pack_slices;

  localparam int F   = 4;
  localparam int CNT = 4;

  logic        clk = 1'b0;
  logic        arst;
  logic [15:0] din;
  logic        in_valid, flush, out_ready;
  logic        in_ready, out_valid;
  logic [15:0] dout;
  logic [31:0] out_cnt;

  logic [31:0] b_in;
  logic        b_in_valid, b_in_ready, b_out_valid;
  logic [23:0] b_out;
  logic [31:0] b_out_cnt;

  always #5 clk = ~clk;

  coreir_pack_slices dut (
    .clk(clk), .arst(arst), .in(din), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out(dout), .out_cnt(out_cnt), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  coreir_pack_slices #(.width(32), .hi(9), .lo(1), .count(3)) dut_b (
    .clk(clk), .arst(arst), .in(b_in), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .flush(1'b0), .out(b_out), .out_cnt(b_out_cnt), .out_valid(b_out_valid),
    .out_ready(1'b1)
  );

  int checks = 0;
  int passes = 0;

  // Reference model: buffered fields as a queue, output slot as plain variables.
  int          q[$];
  bit          m_valid;
  logic [15:0] m_word;
  int          m_cnt;
  bit          m_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_valid = 0; m_word = '0; m_cnt = 0; m_pend = 0;
  endtask

  task automatic model_emit();
    logic [15:0] w;
    w = '0;
    foreach (q[i]) w = w | (16'(q[i]) << (i * F));
    m_word = w; m_cnt = q.size(); m_valid = 1; m_pend = 0;
    q.delete();
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".out"},       32'(dout),      32'(m_word));
    chk({tag, ".out_cnt"},   out_cnt,        32'(m_cnt));
  endtask

  // One clock cycle of stimulus with model prediction and checks.
  task automatic step(input string tag, input bit iv, input logic [15:0] d,
                      input bit fl, input bit ordy);
    bit slot, full_before, rdy, acc, emitted, pend2;
    @(negedge clk);
    in_valid = iv; din = d; flush = fl; out_ready = ordy;
    #1;
    slot        = !m_valid || ordy;
    full_before = (q.size() == CNT - 1);
    rdy         = slot || !full_before;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    acc     = iv && rdy;
    pend2   = m_pend || fl;
    emitted = 0;
    if (acc) q.push_back(int'(d[15:12]));
    if (acc && full_before) begin
      model_emit(); emitted = 1;
    end else if (pend2 && slot && q.size() > 0) begin
      model_emit(); emitted = 1;
    end else begin
      m_pend = pend2 && (q.size() > 0);
    end
    if (!emitted && m_valid && ordy) m_valid = 0;
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  initial begin
    arst = 1'b0; din = '0; in_valid = 0; flush = 0; out_ready = 1;
    b_in = '0; b_in_valid = 0;
    model_reset();
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out",       32'(dout),      32'd0);
    chk("rst.out_cnt",   out_cnt,        32'd0);
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    @(negedge clk); arst = 1'b1;

    // Basic full word
    step("w1a", 1, 16'h1000, 0, 1);
    step("w1b", 1, 16'h2000, 0, 1);
    step("w1c", 1, 16'h3000, 0, 1);
    step("w1d", 1, 16'h4000, 0, 1);
    chk("full.out", 32'(dout), 32'h4321);
    chk("full.cnt", out_cnt, 32'd4);
    chk("full.vld", 32'(out_valid), 32'd1);
    step("w1e", 0, 16'h0, 0, 1);
    chk("full.drain", 32'(out_valid), 32'd0);

    // Partial flush, then a flush with nothing buffered
    step("f1a", 1, 16'hA000, 0, 1);
    step("f1b", 1, 16'hB000, 0, 1);
    step("f1c", 0, 16'h0, 1, 1);
    chk("flush.out", 32'(dout), 32'h00BA);
    chk("flush.cnt", out_cnt, 32'd2);
    step("f1d", 0, 16'h0, 1, 1);
    step("f1e", 0, 16'h0, 0, 1);
    chk("flush.empty", 32'(out_valid), 32'd0);

    // Backpressure: one word held, next word waits at its last field
    step("bp1", 1, 16'h1000, 0, 0);
    step("bp2", 1, 16'h2000, 0, 0);
    step("bp3", 1, 16'h3000, 0, 0);
    step("bp4", 1, 16'h4000, 0, 0);
    step("bp5", 1, 16'h5000, 0, 0);
    step("bp6", 1, 16'h6000, 0, 0);
    step("bp7", 1, 16'h7000, 0, 0);
    step("bp8", 1, 16'h8000, 0, 0);
    chk("bp.stall_ready", 32'(in_ready), 32'd0);
    chk("bp.held",        32'(dout),     32'h4321);
    step("bp9", 1, 16'h8000, 0, 1);
    chk("bp.no_bubble", 32'(out_valid), 32'd1);
    chk("bp.next",      32'(dout),      32'h8765);
    step("bpA", 0, 16'h0, 0, 1);

    // Flush coinciding with the completing field
    step("fc1", 1, 16'h9000, 0, 1);
    step("fc2", 1, 16'hA000, 0, 1);
    step("fc3", 1, 16'hB000, 0, 1);
    step("fc4", 1, 16'hC000, 1, 1);
    chk("fc.cnt", out_cnt, 32'd4);
    chk("fc.out", 32'(dout), 32'hCBA9);
    step("fc5", 1, 16'hD000, 0, 1);
    step("fc6", 0, 16'h0, 0, 1);
    chk("fc.no_pend", 32'(out_valid), 32'd0);
    step("fc7", 0, 16'h0, 1, 1);

    // Asynchronous reset mid-word with an output still held
    step("ar0", 1, 16'h1000, 0, 0);
    step("ar1", 1, 16'h2000, 0, 0);
    step("ar2", 1, 16'h3000, 0, 0);
    step("ar3", 1, 16'h4000, 0, 0);
    step("ar4", 1, 16'h5000, 0, 0);
    step("ar5", 1, 16'h6000, 0, 0);
    in_valid = 0;
    #2;
    arst = 1'b0;
    #1;
    model_reset();
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.out",       32'(dout),      32'd0);
    chk("arst.out_cnt",   out_cnt,        32'd0);
    chk("arst.in_ready",  32'(in_ready),  32'd1);
    @(negedge clk); arst = 1'b1;
    step("ar6", 1, 16'hE000, 0, 1);
    step("ar7", 1, 16'hF000, 0, 1);
    step("ar8", 1, 16'h1000, 0, 1);
    step("ar9", 1, 16'h2000, 0, 1);
    chk("arst.newword", 32'(dout), 32'h21FE);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step("rnd", $urandom_range(0, 3) != 0, 16'($urandom),
           $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end

    // Non-default geometry: 32-bit input, field [8:1], three fields
    @(negedge clk); b_in_valid = 1; b_in = 32'h1FE;
    #1 chk("b.rdy0", 32'(b_in_ready), 32'd1);
    @(negedge clk); b_in = 32'h002;
    @(negedge clk); b_in = 32'h100;
    @(posedge clk); #1;
    chk("b.out",   32'(b_out),       32'h8001FF);
    chk("b.cnt",   b_out_cnt,        32'd3);
    chk("b.valid", 32'(b_out_valid), 32'd1);
    @(negedge clk); b_in_valid = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
